// File: rtl/iobus_pkg.sv
// Shared types and constants for the onboard peripheral bus initiator.
package iobus_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_LW = 4;

  // Bus direction encoding on the rw line.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Onboard register map.
  localparam logic [3:0] LEDS     = 4'h0;
  localparam logic [3:0] LED7HI   = 4'h1;
  localparam logic [3:0] LED7LO   = 4'h2;
  localparam logic [3:0] RGB      = 4'h3;
  localparam logic [3:0] KEYS     = 4'h4;
  localparam logic [3:0] TMR_MODE = 4'h8;
  localparam logic [3:0] TMR_PS2  = 4'h9;
  localparam logic [3:0] TMR_PS1  = 4'hA;
  localparam logic [3:0] TMR_PS0  = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    WFETCH,
    ISSUE,
    CAPT,
    GAPW
  } state_t;

endpackage

// File: rtl/iobus_master.sv
// Bus initiator: turns single/burst read/write commands into one-cycle cs
// strobes on the AD/DI/DO/rw/cs peripheral bus. Every bus-facing output is
// a flop so cs can never glitch.
module iobus_master
  import iobus_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  parameter int LW  = DEF_LW,
  parameter int GAP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_inc,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [AW-1:0] AD,
  output logic [DW-1:0] DO,
  input  logic [DW-1:0] DI,
  output logic          rw,
  output logic          cs
);

  localparam int GCW = 4;
  // GAPW lasts GAP cycles: the counter counts GAP-1 down to 0.
  localparam logic [GCW-1:0] GAP_LOAD = (GAP > 0) ? GCW'(GAP - 1) : '0;

  state_t         state, state_n;
  logic [AW-1:0]  addr, addr_n;
  logic [LW-1:0]  cnt, cnt_n;
  logic           rw_l, rw_n;
  logic           inc_l, inc_n;
  logic [GCW-1:0] gap_cnt;

  logic stop;      // abort honoured this cycle
  logic beat_end;  // current beat finishes at this edge
  logic finish;    // command ends at this edge
  logic capture;   // DI is sampled at this edge
  logic wr_take;   // write beat handshake at this edge

  assign cmd_ready = (state == IDLE) && rst;
  assign wr_ready  = (state == WFETCH) && !abort;
  assign busy      = (state != IDLE);

  // Next-state and command-context update.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    cnt_n    = cnt;
    rw_n     = rw_l;
    inc_n    = inc_l;
    stop     = (state != IDLE) && abort;
    beat_end = 1'b0;
    finish   = 1'b0;
    capture  = 1'b0;
    wr_take  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rw_n    = cmd_rw;
          addr_n  = cmd_addr;
          cnt_n   = cmd_len;
          inc_n   = cmd_inc;
          state_n = (cmd_rw == RW_READ) ? ISSUE : WFETCH;
        end
      end
      WFETCH: begin
        if (wr_valid) begin
          wr_take = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (rw_l == RW_READ) state_n = CAPT;
        else                 beat_end = 1'b1;
      end
      CAPT: begin
        capture  = 1'b1;
        beat_end = 1'b1;
      end
      GAPW: begin
        if (gap_cnt == '0) state_n = (rw_l == RW_READ) ? ISSUE : WFETCH;
      end
      default: state_n = IDLE;
    endcase

    if (beat_end) begin
      if (cnt == '0) begin
        finish  = 1'b1;
        state_n = IDLE;
      end else begin
        cnt_n  = cnt - LW'(1);
        addr_n = inc_l ? addr + AW'(1) : addr;
        if (GAP > 0)               state_n = GAPW;
        else if (rw_l == RW_READ)  state_n = ISSUE;
        else                       state_n = WFETCH;
      end
    end

    // Abort wins over everything: a strobe already on the bus has happened,
    // but nothing further is issued and a pending capture is dropped.
    if (stop) begin
      state_n = IDLE;
      finish  = 1'b1;
      capture = 1'b0;
      wr_take = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so each flop sees
  // pre-edge values no matter how the always blocks are ordered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Command context and inter-strobe gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr    <= '0;
      cnt     <= '0;
      rw_l    <= RW_READ;
      inc_l   <= 1'b0;
      gap_cnt <= '0;
    end else begin
      addr  <= addr_n;
      cnt   <= cnt_n;
      rw_l  <= rw_n;
      inc_l <= inc_n;
      if (state_n == GAPW && state != GAPW) gap_cnt <= GAP_LOAD;
      else if (state == GAPW)               gap_cnt <= gap_cnt - GCW'(1);
    end
  end

  // Registered bus and client outputs; cs is high exactly in ISSUE cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs       <= 1'b0;
      rw       <= RW_READ;
      AD       <= '0;
      DO       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      cs <= (state_n == ISSUE);
      if (state_n == ISSUE) begin
        AD <= addr_n;
        rw <= rw_n;
      end
      if (wr_take) DO <= wr_data;
      rd_valid <= capture;
      if (capture) rd_data <= DI;
      done    <= finish;
      aborted <= stop;
    end
  end

endmodule

// File: tb/tb_iobus_master.sv
// Self-checking bench for iobus_master: scoreboard queues filled by the
// stimulus side, drained by a negedge monitor, plus a GAP=2 instance.
module tb_iobus_master;

  localparam int GAP_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- main DUT (GAP = 0) ----------------
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_rw, cmd_inc;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] wr_data, rd_data;
  logic       wr_valid, wr_ready, rd_valid, abort, busy, done, aborted;
  logic [3:0] AD;
  logic [7:0] DO, DI;
  logic       rw, cs;

  iobus_master #(.AW(4), .DW(8), .LW(4), .GAP(0)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_inc(cmd_inc),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .AD(AD), .DO(DO), .DI(DI), .rw(rw), .cs(cs)
  );

  // Responder: 16 registers with registered read data; preload port for setup.
  logic [7:0] mem [16];
  logic [7:0] resp_do;
  logic       pl_en;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr] <= pl_data;
    else if (cs && !rw) mem[AD] <= DO;
    if (cs && rw)       resp_do <= mem[AD];
  end
  assign DI = resp_do;

  // ---------------- GAP = 2 DUT ----------------
  logic       g_cmd_valid, g_cmd_ready, g_wr_ready, g_rd_valid, g_busy, g_done, g_aborted;
  logic [7:0] g_rd_data, g_DO, g_DI, g_do;
  logic [3:0] g_AD;
  logic       g_rw, g_cs;

  iobus_master #(.AW(4), .DW(8), .LW(4), .GAP(GAP_B)) u_gap (
    .clk(clk), .rst(rst),
    .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready), .cmd_rw(1'b1),
    .cmd_addr(4'h5), .cmd_len(4'd1), .cmd_inc(1'b1),
    .wr_data(8'h00), .wr_valid(1'b0), .wr_ready(g_wr_ready),
    .rd_data(g_rd_data), .rd_valid(g_rd_valid), .abort(1'b0),
    .busy(g_busy), .done(g_done), .aborted(g_aborted),
    .AD(g_AD), .DO(g_DO), .DI(g_DI), .rw(g_rw), .cs(g_cs)
  );

  always @(posedge clk) if (g_cs && g_rw) g_do <= {4'h0, g_AD} ^ 8'hA5;
  assign g_DI = g_do;

  int         g_cs_t[$], g_rd_t[$], g_done_t[$];
  logic [7:0] g_rd_d[$];
  always @(negedge clk) begin
    if (rst) begin
      if (g_cs) g_cs_t.push_back(cyc);
      if (g_rd_valid) begin
        g_rd_t.push_back(cyc);
        g_rd_d.push_back(g_rd_data);
      end
      if (g_done) g_done_t.push_back(cyc);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [3:0] a; logic r; logic [7:0] d; int t; } strobe_t;
  typedef struct { logic [7:0] d; int t; } rd_t;
  typedef struct { logic ab; int t; } done_t;

  strobe_t sq[$];
  rd_t     rq[$];
  done_t   dq[$];
  logic [7:0] ref_mem [16];

  strobe_t se;
  rd_t     re;
  done_t   de;
  logic    prev_cs = 1'b0;
  logic    prev_hs = 1'b0;
  int      last_cs_t = 0;

  // Monitor: compares every observed bus strobe, read beat and completion.
  always @(negedge clk) begin
    if (!rst) begin
      prev_cs = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (cs) begin
        check("cs_back_to_back", prev_cs, 1'b0);
        if (sq.size() == 0) check("cs_unexpected", sq.size(), 1);
        else begin
          se = sq.pop_front();
          check("strobe_addr", AD, se.a);
          check("strobe_rw", rw, se.r);
          if (!se.r) begin
            check("strobe_wdata", DO, se.d);
            check("strobe_after_wr_beat", prev_hs, 1'b1);
          end
          if (se.t >= 0) check("strobe_cycle", cyc, se.t);
        end
        last_cs_t = cyc;
      end
      if (rd_valid) begin
        if (rq.size() == 0) check("rd_unexpected", rq.size(), 1);
        else begin
          re = rq.pop_front();
          check("rd_data", rd_data, re.d);
          if (re.t >= 0) check("rd_cycle", cyc, re.t);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", dq.size(), 1);
        else begin
          de = dq.pop_front();
          check("done_aborted", aborted, de.ab);
          check("busy_low_at_done", busy, 1'b0);
          check("ready_at_done", cmd_ready, 1'b1);
          if (de.t >= 0) check("done_cycle", cyc, de.t);
          else           check("done_after_last_wr", cyc, last_cs_t + 1);
        end
      end else if (aborted) begin
        check("aborted_without_done", aborted, 1'b0);
      end
      if (wr_ready) check("wr_ready_only_wfetch", busy && !cs, 1'b1);
      prev_cs = cs;
      prev_hs = wr_valid && wr_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one command, pushes the expected bus/read/done events, then feeds
  // write beats. stall_beat < 0 gives random 0..2 cycle stalls per beat.
  task automatic run_cmd(input logic r, input logic [3:0] a, input logic [3:0] len,
                         input logic inc, input int d0, input int stall_beat,
                         input int stall, input logic timed);
    int n;
    int t0;
    logic [7:0] wd [16];
    logic [3:0] ai;
    cmd_valid = 1'b1; cmd_rw = r; cmd_addr = a; cmd_len = len; cmd_inc = inc;
    n = 0;
    while (!cmd_ready && n < 400) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    t0 = cyc;
    for (int i = 0; i <= int'(len); i++) begin
      ai = a + (inc ? 4'(i) : 4'd0);
      if (r) begin
        sq.push_back('{ai, 1'b1, 8'h00, t0 + 1 + 2 * i});
        rq.push_back('{ref_mem[ai], t0 + 3 + 2 * i});
      end else begin
        wd[i] = (d0 >= 0) ? 8'(d0 + i) : 8'($urandom);
        ref_mem[ai] = wd[i];
        sq.push_back('{ai, 1'b0, wd[i], timed ? t0 + 2 + 2 * i : -1});
      end
    end
    dq.push_back('{1'b0, (r || timed) ? t0 + 3 + 2 * int'(len) : -1});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_addr = 4'($urandom); cmd_len = 4'($urandom);
    if (!r) begin
      for (int i = 0; i <= int'(len); i++) begin
        int k;
        k = (stall_beat < 0) ? int'($urandom_range(0, 2)) : ((i == stall_beat) ? stall : 0);
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
        if (k > 0) repeat (k) begin @(posedge clk); #1; end
        wr_valid = 1'b1;
        wr_data  = wd[i];
        n = 0;
        while (!wr_ready && n < 400) begin @(posedge clk); #1; n++; end
        if (!wr_ready) begin
          check("wr_ready_timeout", wr_ready, 1'b1);
          wr_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || sq.size() != 0 || rq.size() != 0 || dq.size() != 0) && n < 600) begin
      @(posedge clk); #1; n++;
    end
    check("drain_pending", busy || sq.size() != 0 || rq.size() != 0 || dq.size() != 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_inc = 1'b0;
    wr_data = '0; wr_valid = 1'b0; abort = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    g_cmd_valid = 1'b0;

    // Reset values, and random responder contents while held in reset.
    repeat (2) @(posedge clk); #1;
    check("rst_cs", cs, 1'b0);
    check("rst_rw", rw, 1'b1);
    check("rst_AD", AD, 4'h0);
    check("rst_DO", DO, 8'h00);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_flags", {rd_valid, done, aborted, busy, wr_ready}, 5'b0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    for (int i = 0; i < 16; i++) preload(4'(i), 8'($urandom));
    rst = 1'b1; #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    // Single write, wr_valid held: cs in cycle 2, done in cycle 3.
    run_cmd(1'b0, 4'h0, 4'd0, 1'b0, 'h5A, 0, 0, 1'b1);
    drain();

    // Read burst 9..B returning 11/22/33.
    preload(4'h9, 8'h11); preload(4'hA, 8'h22); preload(4'hB, 8'h33);
    run_cmd(1'b1, 4'h9, 4'd2, 1'b1, -1, 0, 0, 1'b1);
    drain();

    // Address wrap with and without increment.
    run_cmd(1'b1, 4'hE, 4'd3, 1'b1, -1, 0, 0, 1'b1);
    run_cmd(1'b1, 4'hE, 4'd3, 1'b0, -1, 0, 0, 1'b1);
    drain();

    // Write burst with a 4-cycle data stall before beat 1.
    run_cmd(1'b0, 4'h6, 4'd1, 1'b1, 'hC0, 1, 4, 1'b0);
    drain();

    // Abort in IDLE does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_ready", cmd_ready, 1'b1);

    // Abort during CAPT of beat 0 of a 4-beat read.
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 4'h2; cmd_len = 4'd3; cmd_inc = 1'b1;
    t0 = cyc;
    sq.push_back('{4'h2, 1'b1, 8'h00, t0 + 1});
    dq.push_back('{1'b1, t0 + 3});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ready_in_abort_done", cmd_ready, 1'b1);
    run_cmd(1'b1, 4'h4, 4'd0, 1'b0, -1, 0, 0, 1'b1);
    drain();

    // Randomized commands, back to back, including full 16-beat bursts.
    for (int k = 0; k < 40; k++) begin
      logic [3:0] ln;
      ln = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      run_cmd(1'($urandom), 4'($urandom), ln, 1'($urandom), -1, -1, 0, 1'b0);
    end
    drain();

    // GAP=2 instance, read len 1 from address 5.
    g_cmd_valid = 1'b1;
    n = 0;
    while (!g_cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("gap_ready", g_cmd_ready, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    g_cmd_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("gap_cs_count", g_cs_t.size(), 2);
    if (g_cs_t.size() == 2) begin
      check("gap_cs0_cycle", g_cs_t[0], t0 + 1);
      check("gap_cs1_cycle", g_cs_t[1], t0 + 3 + GAP_B);
      check("gap_idle_ge3", (g_cs_t[1] - g_cs_t[0] - 1) >= 3, 1'b1);
    end
    check("gap_rd_count", g_rd_t.size(), 2);
    if (g_rd_t.size() == 2) begin
      check("gap_rd0", g_rd_d[0], 8'h05 ^ 8'hA5);
      check("gap_rd1", g_rd_d[1], 8'h06 ^ 8'hA5);
      check("gap_rd1_cycle", g_rd_t[1], t0 + 5 + GAP_B);
    end
    check("gap_done_count", g_done_t.size(), 1);
    if (g_done_t.size() == 1) check("gap_done_cycle", g_done_t[0], t0 + 5 + GAP_B);

    // Reset asserted mid-ISSUE drops cs without a clock edge.
    run_cmd(1'b1, 4'h3, 4'd2, 1'b1, -1, 0, 0, 1'b1);
    check("cs_before_reset", cs, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("midrst_cs", cs, 1'b0);
    check("midrst_rw", rw, 1'b1);
    check("midrst_AD", AD, 4'h0);
    check("midrst_DO", DO, 8'h00);
    check("midrst_rd_data", rd_data, 8'h00);
    check("midrst_flags", {rd_valid, done, aborted, busy, wr_ready, cmd_ready}, 6'b0);
    sq.delete(); rq.delete(); dq.delete();
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("ready_after_midrst", cmd_ready, 1'b1);
    run_cmd(1'b0, 4'h7, 4'd0, 1'b0, 'h3C, 0, 0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
